// File: rtl/slc3_sram_responder.sv
// slc3_sram_responder
//   Memory-side responder for the SLC-3 CPU bus. Replaces the board SRAM with
//   an on-chip word-addressed RAM and answers MAR/OE/WE requests with a
//   programmable read latency and a one-cycle Ready pulse per request.
//
// Ports
//   Clk            rising-edge clock
//   Reset          asynchronous, active-low reset
//   ADDR           word address from CPU MAR (latched at acceptance)
//   OE / WE        read / write request levels, active-high
//   Data_to_SRAM   write data from CPU
//   Data_from_SRAM read data to CPU, held until the next read completes
//   Ready          one-cycle completion pulse per accepted request
//   Err            sticky: OE and WE both high at acceptance, or ADDR >= DEPTH
//   Init_En        side-band preload strobe (honoured only in IDLE)
//   Init_Addr      side-band preload address
//   Init_Data      side-band preload data
module slc3_sram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  output logic        Ready,
  output logic        Err,
  input  logic        Init_En,
  input  logic [15:0] Init_Addr,
  input  logic [15:0] Init_Data
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(READ_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [15:0] mem [DEPTH];

  logic [15:0] addr_q;
  logic [3:0]  wait_q;
  logic [15:0] data_q;
  logic        ready_q;
  logic        err_q;

  logic acc_rd, acc_wr, init_wr, rd_done;
  logic bus_ok, init_ok, addr_q_ok;

  assign bus_ok    = {1'b0, ADDR}      < DEPTH_W;
  assign init_ok   = {1'b0, Init_Addr} < DEPTH_W;
  assign addr_q_ok = {1'b0, addr_q}    < DEPTH_W;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    init_wr = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Preload wins the cycle; a pending bus request is taken next edge.
        if (Init_En) begin
          init_wr = 1'b1;
        end else if (WE) begin
          acc_wr  = 1'b1;
          state_d = S_WRITE;
        end else if (OE) begin
          acc_rd  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (wait_q == 4'd0) begin
          rd_done = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_WRITE: state_d = S_HOLD;
      S_HOLD: begin
        if (!OE && !WE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers. A write commits on its acceptance edge, so only the
  // read address needs to survive past acceptance.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= acc_wr | rd_done;
      if (acc_rd || acc_wr) addr_q <= ADDR;
      if (acc_rd) begin
        wait_q <= WAIT_LD;
      end else if (state_q == S_READ && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (rd_done) data_q <= addr_q_ok ? mem[addr_q[AW-1:0]] : '0;
      if ((acc_wr && (OE || !bus_ok)) || (acc_rd && !bus_ok)) err_q <= 1'b1;
    end
  end

  // RAM array: no reset, contents survive Reset. Writes are blocked while
  // Reset is low so an asynchronous abort cannot commit a stray word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (init_wr && init_ok) begin
        mem[Init_Addr[AW-1:0]] <= Init_Data;
      end else if (acc_wr && bus_ok) begin
        mem[ADDR[AW-1:0]] <= Data_to_SRAM;
      end
    end
  end

  assign Data_from_SRAM = data_q;
  assign Ready          = ready_q;
  assign Err            = err_q;

endmodule
